// File: rtl/audiodac_fifo_sched_pkg.sv
// Shared constants for the audio DAC sample path: scheduler state encoding,
// default widths and the modulator midscale value.
package audiodac_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREFILL  = 2'd1,
    RUN      = 2'd2,
    UNDERRUN = 2'd3
  } sched_state_e;

  localparam int unsigned FIFO_SIZE_DEF = 5;
  localparam int unsigned DIV_WIDTH_DEF = 12;
  localparam int unsigned CNT_WIDTH_DEF = 8;
  localparam int unsigned SAMPLE_WIDTH  = 16;
  localparam logic [SAMPLE_WIDTH-1:0] MIDSCALE = 16'h8000;

  function automatic logic is_active(sched_state_e s);
    return s != IDLE;
  endfunction

endpackage

// File: rtl/audiodac_fifo_sched_tick_gen.sv
// Reloadable down-counter: ticks when it reaches zero, giving one tick every
// rate_div_i+1 cycles; held at rate_div_i while load_i is high.
module audiodac_tick_gen #(
  parameter int unsigned DIV_WIDTH = 12
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 load_i,
  input  logic [DIV_WIDTH-1:0] rate_div_i,
  output logic                 tick_o
);

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    tick_o = !load_i && (cnt_q == '0);
    if (load_i || tick_o) cnt_d = rate_div_i;
    else                  cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/audiodac_fifo_sched.sv
// Read-side scheduler for the audio DAC sample FIFO: sample tick, read pulses,
// fill tracking, prefill/underrun handling. Underrun counter kept only with AUDIODAC_FIFO_SCHED_STATS_EN.
module audiodac_fifo_sched
  import audiodac_pkg::*;
#(
  parameter int unsigned FIFO_SIZE = FIFO_SIZE_DEF,
  parameter int unsigned DIV_WIDTH = DIV_WIDTH_DEF,
  parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 enable_i,
  input  logic [DIV_WIDTH-1:0] rate_div_i,
  input  logic [FIFO_SIZE-1:0] low_wm_i,
  input  logic                 fifo_empty_i,
  input  logic                 fifo_full_i,
  input  logic                 fifo_wr_ack_i,
  output logic                 fifo_rd_o,
  output logic                 sample_stb_o,
  output logic [FIFO_SIZE-1:0] fill_level_o,
  output logic                 refill_req_o,
  output logic                 mute_o,
  output logic [CNT_WIDTH-1:0] underrun_cnt_o
);

  localparam logic [FIFO_SIZE-1:0] LEVEL_MAX = '1;

  sched_state_e         state_q, state_d;
  logic                 ack_q;
  logic [FIFO_SIZE-1:0] level_q, level_d;
  logic                 rd_q, rd_d, stb_q, stb_d, refill_q, refill_d, mute_q, mute_d;
  logic                 tick, wr_ev, fill_ok, underrun_ev;

  audiodac_tick_gen #(.DIV_WIDTH(DIV_WIDTH)) u_tick_gen (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .load_i     (!is_active(state_q)),
    .rate_div_i (rate_div_i),
    .tick_o     (tick)
  );

  always_comb begin
    wr_ev       = fifo_wr_ack_i && !ack_q;
    fill_ok     = (level_q >= low_wm_i) || fifo_full_i;
    state_d     = state_q;
    rd_d        = 1'b0;
    stb_d       = 1'b0;
    underrun_ev = 1'b0;
    if (!enable_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: state_d = PREFILL;
        PREFILL, UNDERRUN: begin
          stb_d = tick;
          if (fill_ok) state_d = RUN;
        end
        RUN: begin
          stb_d = tick;
          if (tick && fifo_empty_i) begin
            state_d     = UNDERRUN;
            underrun_ev = 1'b1;
          end else begin
            rd_d = tick;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    // rd_q is the read the FIFO is consuming this cycle; a coincident write cancels it
    level_d = level_q;
    if (wr_ev && !rd_q && level_q != LEVEL_MAX) level_d = level_q + 1'b1;
    if (rd_q && !wr_ev && level_q != '0)        level_d = level_q - 1'b1;
    refill_d = (level_q < low_wm_i) && !fifo_full_i && enable_i;
    mute_d   = (state_d != RUN);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      ack_q    <= 1'b0;
      level_q  <= '0;
      rd_q     <= 1'b0;
      stb_q    <= 1'b0;
      refill_q <= 1'b0;
      mute_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      ack_q    <= fifo_wr_ack_i;
      level_q  <= level_d;
      rd_q     <= rd_d;
      stb_q    <= stb_d;
      refill_q <= refill_d;
      mute_q   <= mute_d;
    end
  end

`ifdef AUDIODAC_FIFO_SCHED_STATS_EN
  logic [CNT_WIDTH-1:0] ucnt_q, ucnt_d;

  always_comb begin
    ucnt_d = ucnt_q;
    if (underrun_ev && ucnt_q != '1) ucnt_d = ucnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) ucnt_q <= '0;
    else          ucnt_q <= ucnt_d;
  end

  assign underrun_cnt_o = ucnt_q;
`else
  logic unused_underrun_ev;
  assign unused_underrun_ev = underrun_ev;
  assign underrun_cnt_o     = '0;
`endif

  assign fifo_rd_o    = rd_q;
  assign sample_stb_o = stb_q;
  assign fill_level_o = level_q;
  assign refill_req_o = refill_q;
  assign mute_o       = mute_q;

endmodule

// File: tb/tb_audiodac_fifo_sched.sv
// Directed bench for audiodac_fifo_sched; cycle numbers count edges after the
// reset-release edge, with rate_div_i=3 giving strobes on cycles 5, 9, 13, ...
module tb_audiodac_fifo_sched;

  localparam int FS = 5;
  localparam int DW = 12;
  localparam int CW = 8;
`ifdef AUDIODAC_FIFO_SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [DW-1:0] rate_div = 12'd3;
  logic [FS-1:0] low_wm = 5'd4;
  logic          empty = 1'b1;
  logic          full = 1'b0;
  logic          ack = 1'b0;
  logic          rd, stb, refill, mute;
  logic [FS-1:0] level;
  logic [CW-1:0] ucnt;

  int n_checks = 0;
  int n_fails = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  audiodac_fifo_sched #(.FIFO_SIZE(FS), .DIV_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .enable_i       (enable),
    .rate_div_i     (rate_div),
    .low_wm_i       (low_wm),
    .fifo_empty_i   (empty),
    .fifo_full_i    (full),
    .fifo_wr_ack_i  (ack),
    .fifo_rd_o      (rd),
    .sample_stb_o   (stb),
    .fill_level_o   (level),
    .refill_req_o   (refill),
    .mute_o         (mute),
    .underrun_cnt_o (ucnt)
  );

  function automatic logic [CW-1:0] ucnt_exp(input int n);
    if (!STATS) return '0;
    return (n > 255) ? 8'd255 : 8'(n);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; rate_div = 12'd3; low_wm = 5'd4; empty = 1'b1; full = 1'b0; ack = 1'b0;
    repeat (3) step();
    n_checks++; if (rd !== 1'b0)     begin n_fails++; $display("FAIL reset_rd: got %b want 0", rd); end
    n_checks++; if (stb !== 1'b0)    begin n_fails++; $display("FAIL reset_stb: got %b want 0", stb); end
    n_checks++; if (level !== 5'd0)  begin n_fails++; $display("FAIL reset_level: got %0d want 0", level); end
    n_checks++; if (refill !== 1'b0) begin n_fails++; $display("FAIL reset_refill: got %b want 0", refill); end
    n_checks++; if (mute !== 1'b1)   begin n_fails++; $display("FAIL reset_mute: got %b want 1", mute); end
    n_checks++; if (ucnt !== 8'd0)   begin n_fails++; $display("FAIL reset_ucnt: got %0d want 0", ucnt); end
    $display("test_reset done");
  endtask

  task automatic test_config();
    rst_n = 1'b1; enable = 1'b1; cyc = 0;
    step();
    n_checks++; if (mute !== 1'b1)   begin n_fails++; $display("FAIL cfg_mute c1: got %b want 1", mute); end
    n_checks++; if (refill !== 1'b1) begin n_fails++; $display("FAIL cfg_refill c1: got %b want 1", refill); end
    for (int c = 2; c <= 13; c++) begin
      step();
      n_checks++; if (stb !== (c % 4 == 1)) begin n_fails++; $display("FAIL cfg_stb c%0d: got %b want %b", c, stb, c % 4 == 1); end
      n_checks++; if (rd !== 1'b0)   begin n_fails++; $display("FAIL cfg_rd c%0d: got %b want 0", c, rd); end
      n_checks++; if (mute !== 1'b1) begin n_fails++; $display("FAIL cfg_mute c%0d: got %b want 1", c, mute); end
      n_checks++; if (refill !== 1'b1) begin n_fails++; $display("FAIL cfg_refill c%0d: got %b want 1", c, refill); end
    end
    $display("test_config done");
  endtask

  task automatic test_prefill();
    empty = 1'b0;
    for (int c = 14; c <= 21; c++) begin
      ack = (c % 2 == 0);
      step();
      n_checks++; if (stb !== (c % 4 == 1)) begin n_fails++; $display("FAIL pre_stb c%0d: got %b want %b", c, stb, c % 4 == 1); end
      n_checks++; if (rd !== 1'b0) begin n_fails++; $display("FAIL pre_rd c%0d: got %b want 0", c, rd); end
    end
    n_checks++; if (level !== 5'd4)  begin n_fails++; $display("FAIL pre_level: got %0d want 4", level); end
    n_checks++; if (mute !== 1'b0)   begin n_fails++; $display("FAIL pre_run_mute: got %b want 0", mute); end
    n_checks++; if (refill !== 1'b0) begin n_fails++; $display("FAIL pre_refill: got %b want 0", refill); end
    $display("test_prefill done");
  endtask

  task automatic test_reads();
    ack = 1'b0;
    for (int c = 22; c <= 30; c++) begin
      step();
      n_checks++; if (stb !== (c % 4 == 1)) begin n_fails++; $display("FAIL rd_stb c%0d: got %b want %b", c, stb, c % 4 == 1); end
      n_checks++; if (rd !== (c % 4 == 1))  begin n_fails++; $display("FAIL rd_pulse c%0d: got %b want %b", c, rd, c % 4 == 1); end
      if (c == 26) begin n_checks++; if (level !== 5'd3) begin n_fails++; $display("FAIL rd_level c26: got %0d want 3", level); end end
      if (c == 30) begin n_checks++; if (level !== 5'd2) begin n_fails++; $display("FAIL rd_level c30: got %0d want 2", level); end end
    end
    $display("test_reads done");
  endtask

  task automatic test_simultaneous();
    for (int c = 31; c <= 51; c++) begin
      ack = ((c % 2 == 1) && (c <= 39)) || (c >= 42);
      step();
      n_checks++; if (rd !== (c % 4 == 1)) begin n_fails++; $display("FAIL sim_rd c%0d: got %b want %b", c, rd, c % 4 == 1); end
      if (c == 39 || c == 41 || c == 42 || c == 43) begin
        n_checks++; if (level !== 5'd5) begin n_fails++; $display("FAIL sim_level c%0d: got %0d want 5", c, level); end
      end
      if (c == 51) begin n_checks++; if (level !== 5'd3) begin n_fails++; $display("FAIL sim_held_ack c51: got %0d want 3", level); end end
    end
    $display("test_simultaneous done");
  endtask

  task automatic test_underrun();
    ack = 1'b0;
    for (int c = 52; c <= 65; c++) begin
      empty = (c >= 63);
      step();
      n_checks++; if (stb !== (c % 4 == 1)) begin n_fails++; $display("FAIL ur_stb c%0d: got %b want %b", c, stb, c % 4 == 1); end
      n_checks++; if (rd !== ((c % 4 == 1) && (c < 65))) begin n_fails++; $display("FAIL ur_rd c%0d: got %b", c, rd); end
      if (c == 62) begin n_checks++; if (level !== 5'd0) begin n_fails++; $display("FAIL ur_level c62: got %0d want 0", level); end end
      if (c == 64) begin n_checks++; if (mute !== 1'b0) begin n_fails++; $display("FAIL ur_mute c64: got %b want 0", mute); end end
    end
    n_checks++; if (mute !== 1'b1) begin n_fails++; $display("FAIL ur_mute c65: got %b want 1", mute); end
    n_checks++; if (ucnt !== ucnt_exp(1)) begin n_fails++; $display("FAIL ur_cnt: got %0d want %0d", ucnt, ucnt_exp(1)); end
    $display("test_underrun done");
  endtask

  task automatic test_recover();
    for (int c = 66; c <= 77; c++) begin
      ack = (c % 2 == 0) && (c <= 72);
      empty = (c < 67);
      step();
      n_checks++; if (stb !== (c % 4 == 1)) begin n_fails++; $display("FAIL rec_stb c%0d: got %b want %b", c, stb, c % 4 == 1); end
      n_checks++; if (rd !== (c == 77)) begin n_fails++; $display("FAIL rec_rd c%0d: got %b want %b", c, rd, c == 77); end
      n_checks++; if (mute !== (c < 73)) begin n_fails++; $display("FAIL rec_mute c%0d: got %b want %b", c, mute, c < 73); end
      if (c == 72 || c == 77) begin
        n_checks++; if (level !== 5'd4) begin n_fails++; $display("FAIL rec_level c%0d: got %0d want 4", c, level); end
      end
    end
    n_checks++; if (ucnt !== ucnt_exp(1)) begin n_fails++; $display("FAIL rec_cnt: got %0d want %0d", ucnt, ucnt_exp(1)); end
    $display("test_recover done");
  endtask

  task automatic test_disable();
    ack = 1'b0; enable = 1'b0;
    for (int c = 78; c <= 85; c++) begin
      step();
      n_checks++; if (stb !== 1'b0)  begin n_fails++; $display("FAIL dis_stb c%0d: got %b want 0", c, stb); end
      n_checks++; if (rd !== 1'b0)   begin n_fails++; $display("FAIL dis_rd c%0d: got %b want 0", c, rd); end
      n_checks++; if (mute !== 1'b1) begin n_fails++; $display("FAIL dis_mute c%0d: got %b want 1", c, mute); end
    end
    n_checks++; if (level !== 5'd3) begin n_fails++; $display("FAIL dis_level: got %0d want 3", level); end
    n_checks++; if (ucnt !== ucnt_exp(1)) begin n_fails++; $display("FAIL dis_cnt: got %0d want %0d", ucnt, ucnt_exp(1)); end
    n_checks++; if (refill !== 1'b0) begin n_fails++; $display("FAIL dis_refill: got %b want 0", refill); end
    $display("test_disable done");
  endtask

  task automatic test_full_flag();
    enable = 1'b1;
    for (int c = 86; c <= 90; c++) begin
      full = (c == 88);
      step();
      n_checks++; if (stb !== (c == 90)) begin n_fails++; $display("FAIL full_stb c%0d: got %b want %b", c, stb, c == 90); end
      if (c == 87) begin
        n_checks++; if (mute !== 1'b1)   begin n_fails++; $display("FAIL full_mute c87: got %b want 1", mute); end
        n_checks++; if (refill !== 1'b1) begin n_fails++; $display("FAIL full_refill c87: got %b want 1", refill); end
      end
      if (c == 88) begin
        n_checks++; if (mute !== 1'b0)   begin n_fails++; $display("FAIL full_run c88: got %b want 0", mute); end
        n_checks++; if (refill !== 1'b0) begin n_fails++; $display("FAIL full_refill c88: got %b want 0", refill); end
      end
    end
    full = 1'b0;
    n_checks++; if (rd !== 1'b1)     begin n_fails++; $display("FAIL full_rd c90: got %b want 1", rd); end
    n_checks++; if (refill !== 1'b1) begin n_fails++; $display("FAIL full_refill c90: got %b want 1", refill); end
    $display("test_full_flag done");
  endtask

  task automatic test_async_reset();
    rst_n = 1'b0;
    #2;
    n_checks++; if (stb !== 1'b0)    begin n_fails++; $display("FAIL arst_stb: got %b want 0", stb); end
    n_checks++; if (rd !== 1'b0)     begin n_fails++; $display("FAIL arst_rd: got %b want 0", rd); end
    n_checks++; if (level !== 5'd0)  begin n_fails++; $display("FAIL arst_level: got %0d want 0", level); end
    n_checks++; if (refill !== 1'b0) begin n_fails++; $display("FAIL arst_refill: got %b want 0", refill); end
    n_checks++; if (mute !== 1'b1)   begin n_fails++; $display("FAIL arst_mute: got %b want 1", mute); end
    n_checks++; if (ucnt !== 8'd0)   begin n_fails++; $display("FAIL arst_cnt: got %0d want 0", ucnt); end
    step(); step();
    enable = 1'b0; rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if ((stb | rd) !== 1'b0) begin n_fails++; $display("FAIL arst_release %0d: stb %b rd %b want 0", i, stb, rd); end
      n_checks++; if (mute !== 1'b1) begin n_fails++; $display("FAIL arst_release_mute %0d: got %b want 1", i, mute); end
    end
    $display("test_async_reset done");
  endtask

  task automatic test_saturation();
    rate_div = 12'd0; low_wm = 5'd0; empty = 1'b1; full = 1'b0; ack = 1'b0; enable = 1'b1; cyc = 0;
    for (int c = 1; c <= 700; c++) begin
      step();
      n_checks++; if (rd !== 1'b0) begin n_fails++; $display("FAIL sat_rd c%0d: got %b want 0", c, rd); end
      if (c == 10) begin n_checks++; if (ucnt !== ucnt_exp(4)) begin n_fails++; $display("FAIL sat_cnt c10: got %0d want %0d", ucnt, ucnt_exp(4)); end end
    end
    n_checks++; if (ucnt !== ucnt_exp(349)) begin n_fails++; $display("FAIL sat_cnt c700: got %0d want %0d", ucnt, ucnt_exp(349)); end
    $display("test_saturation done");
  endtask

  initial begin
    test_reset();
    test_config();
    test_prefill();
    test_reads();
    test_simultaneous();
    test_underrun();
    test_recover();
    test_disable();
    test_full_flag();
    test_async_reset();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
